// File: rtl/ls_pkg.sv
// Shared op codes, FSM states and lane widths for the load/store sequencer.
// Build option: LS_MISALIGN_TRAP_EN selects trapping of misaligned accesses.
package ls_pkg;

  localparam logic [2:0] OP_LW = 3'b000;
  localparam logic [2:0] OP_LH = 3'b001;
  localparam logic [2:0] OP_LB = 3'b010;
  localparam logic [2:0] OP_SW = 3'b100;
  localparam logic [2:0] OP_SH = 3'b101;
  localparam logic [2:0] OP_SB = 3'b110;

  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;
  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_LD_WB,
    S_WR,
    S_EXC
  } state_t;

  typedef struct packed {
    logic [2:0]        op;
    logic [1:0]        lo;
    logic [WORD_W-1:0] data;
  } req_t;

  function automatic logic op_legal(logic [2:0] op);
    return op[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/ls_ctrl_if.sv
// Request, memory and write-back bundle of the load/store sequencer.
// Master side is the requester plus memory; slave side is ls_ctrl.
interface ls_ctrl_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] st_data;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] ld_data;
  logic        datasrc_sel;
  logic        reg_wr;
  logic        busy;
  logic        done;
  logic        exc;

  modport master (
    output start, op, addr, st_data, mem_rdata,
    input  mem_addr, mem_wr, mem_wdata, ld_data,
    input  datasrc_sel, reg_wr, busy, done, exc
  );

  modport slave (
    input  start, op, addr, st_data, mem_rdata,
    output mem_addr, mem_wr, mem_wdata, ld_data,
    output datasrc_sel, reg_wr, busy, done, exc
  );
endinterface

// File: rtl/ls_lane_unit.sv
// Little-endian lane extract with sign extension for loads and
// lane merge for sub-word stores.
module ls_lane_unit
  import ls_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  a,
  input  logic [2:0]  op,
  input  logic [31:0] st_data,
  output logic [31:0] ld,
  output logic [31:0] merged
);

  logic [BYTE_W-1:0] b;
  logic [HALF_W-1:0] h;

  always_comb begin
    b      = word[{a, 3'b000} +: BYTE_W];
    h      = word[{a[1], 4'b0000} +: HALF_W];
    ld     = word;
    merged = st_data;
    case (op)
      OP_LB: ld = {{(WORD_W-BYTE_W){b[BYTE_W-1]}}, b};
      OP_LH: ld = {{(WORD_W-HALF_W){h[HALF_W-1]}}, h};
      OP_SB: begin
        merged = word;
        merged[{a, 3'b000} +: BYTE_W] = st_data[BYTE_W-1:0];
      end
      OP_SH: begin
        merged = word;
        merged[{a[1], 4'b0000} +: HALF_W] = st_data[HALF_W-1:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ls_ctrl.sv
// Multicycle load/store sequencer: FSM, latency counter, request latch.
// Build option: LS_MISALIGN_TRAP_EN traps misaligned LH/SH/LW/SW.
module ls_ctrl
  import ls_pkg::*;
#(
  parameter int MEM_LAT = 2
)
(
  input logic      clk,
  input logic      reset,
  ls_ctrl_if.slave bus
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_t      state;
  req_t        req;
  logic [CW-1:0] cnt;

  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [31:0] ld_data_q;
  logic        mem_wr_q;
  logic        reg_wr_q;
  logic        sel_q;
  logic        busy_q;
  logic        done_q;
  logic        exc_q;

  logic        is_half;
  logic        is_word;
  logic        mis;
  logic [1:0]  lo;
  logic [31:0] lane_ld;
  logic [31:0] lane_mg;

  assign is_half = bus.op[1:0] == 2'b01;
  assign is_word = bus.op[1:0] == 2'b00;

`ifdef LS_MISALIGN_TRAP_EN
  assign mis = (is_half && bus.addr[0]) ||
               (is_word && bus.addr[1:0] != 2'b00);
  assign lo  = bus.addr[1:0];
`else
  // Misaligned requests are silently aligned down to their access size.
  assign mis = 1'b0;
  assign lo  = is_word ? 2'b00 :
               is_half ? {bus.addr[1], 1'b0} :
                         bus.addr[1:0];
`endif

  ls_lane_unit u_lane (
    .word    (bus.mem_rdata),
    .a       (req.lo),
    .op      (req.op),
    .st_data (req.data),
    .ld      (lane_ld),
    .merged  (lane_mg)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      req         <= '0;
      cnt         <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ld_data_q   <= '0;
      mem_wr_q    <= 1'b0;
      reg_wr_q    <= 1'b0;
      sel_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      exc_q       <= 1'b0;
    end else begin
      mem_wr_q <= 1'b0;
      reg_wr_q <= 1'b0;
      sel_q    <= 1'b0;
      done_q   <= 1'b0;
      exc_q    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            req    <= '{op: bus.op, lo: lo, data: bus.st_data};
            busy_q <= 1'b1;
            if (!op_legal(bus.op) || mis) begin
              state  <= S_EXC;
              exc_q  <= 1'b1;
              done_q <= 1'b1;
            end else if (bus.op == OP_SW) begin
              state       <= S_WR;
              mem_addr_q  <= {bus.addr[31:2], 2'b00};
              mem_wdata_q <= bus.st_data;
              mem_wr_q    <= 1'b1;
              done_q      <= 1'b1;
            end else begin
              state      <= S_RD;
              mem_addr_q <= {bus.addr[31:2], 2'b00};
              cnt        <= CW'(MEM_LAT - 1);
            end
          end
        end
        S_RD: begin
          if (cnt == '0) begin
            done_q <= 1'b1;
            if (!req.op[2]) begin
              state     <= S_LD_WB;
              ld_data_q <= lane_ld;
              reg_wr_q  <= 1'b1;
              sel_q     <= 1'b1;
            end else begin
              state       <= S_WR;
              mem_wdata_q <= lane_mg;
              mem_wr_q    <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_LD_WB, S_WR, S_EXC: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wr      = mem_wr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.ld_data     = ld_data_q;
  assign bus.datasrc_sel = sel_q;
  assign bus.reg_wr      = reg_wr_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.exc         = exc_q;

endmodule

// File: tb/tb_ls_ctrl.sv
// Bench for ls_ctrl: directed literal checks plus random traffic
// compared every cycle against a transaction-level reference model.
module tb_ls_ctrl;

  localparam int MEM_LAT = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ls_ctrl_if bus ();

  ls_ctrl #(.MEM_LAT(MEM_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: one outstanding transaction of length nn
  logic [31:0] mem [64];
  logic        m_busy = 1'b0;
  int          k = 0;
  int          nn = 0;
  logic [2:0]  m_op = '0;
  logic [1:0]  m_lo = '0;
  logic [31:0] m_d = '0;
  logic [31:0] w;
  logic [31:0] e_maddr = '0;
  logic [31:0] e_wdata = '0;
  logic [31:0] e_ld = '0;
  logic        e_wr = 0, e_rw = 0, e_sel = 0, e_done = 0, e_exc = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] eff_lo(logic [2:0] o, logic [31:0] a);
`ifdef LS_MISALIGN_TRAP_EN
    return a[1:0];
`else
    if (o[1:0] == 2'b00) return 2'b00;
    if (o[1:0] == 2'b01) return {a[1], 1'b0};
    return a[1:0];
`endif
  endfunction

  function automatic logic misal(logic [2:0] o, logic [31:0] a);
`ifdef LS_MISALIGN_TRAP_EN
    return (o[1:0] == 2'b01 && a[0]) ||
           (o[1:0] == 2'b00 && a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] extract(logic [2:0] o, logic [1:0] lo,
                                          logic [31:0] x);
    logic [31:0] v;
    if (o[1:0] == 2'b01) begin
      v = (x >> (16 * lo[1])) & 32'hFFFF;
      return v[15] ? (v | 32'hFFFF0000) : v;
    end
    if (o[1:0] == 2'b10) begin
      v = (x >> (8 * lo)) & 32'hFF;
      return v[7] ? (v | 32'hFFFFFF00) : v;
    end
    return x;
  endfunction

  function automatic logic [31:0] merge(logic [2:0] o, logic [1:0] lo,
                                        logic [31:0] x, logic [31:0] d);
    logic [31:0] m;
    int          s;
    s = (o[1:0] == 2'b01) ? 16 * lo[1] : 8 * lo;
    m = ((o[1:0] == 2'b01) ? 32'hFFFF : 32'hFF) << s;
    return (x & ~m) | ((d << s) & m);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 0; k = 0; nn = 0;
      e_maddr = 0; e_wdata = 0; e_ld = 0;
      e_wr = 0; e_rw = 0; e_sel = 0; e_done = 0; e_exc = 0;
      for (int i = 0; i < 64; i++) mem[i] = 32'h9E3779B9 * (i + 1);
    end else begin
      e_wr = 0; e_rw = 0; e_sel = 0; e_done = 0; e_exc = 0;
      if (!m_busy) begin
        if (bus.start) begin
          m_op = bus.op;
          m_lo = eff_lo(bus.op, bus.addr);
          m_d = bus.st_data;
          m_busy = 1; k = 1;
          if (m_op[1:0] == 2'b11 || misal(bus.op, bus.addr)) begin
            nn = 1; e_exc = 1; e_done = 1;
          end else begin
            e_maddr = bus.addr & ~32'h3;
            if (m_op == 3'b100) begin
              nn = 1; e_wr = 1; e_done = 1; e_wdata = m_d;
              mem[e_maddr[7:2]] = m_d;
            end else begin
              nn = MEM_LAT + 1;
            end
          end
        end
      end else if (k == nn) begin
        m_busy = 0;
      end else begin
        k++;
        if (k == nn) begin
          w = mem[e_maddr[7:2]];
          e_done = 1;
          if (!m_op[2]) begin
            e_ld = extract(m_op, m_lo, w); e_rw = 1; e_sel = 1;
          end else begin
            e_wdata = merge(m_op, m_lo, w, m_d); e_wr = 1;
            mem[e_maddr[7:2]] = e_wdata;
          end
        end
      end
    end
  end

  // Memory returns valid data only in the last latency cycle.
  always @(negedge clk) begin
    if (m_busy && k == MEM_LAT && nn == MEM_LAT + 1)
      bus.mem_rdata = mem[e_maddr[7:2]];
    else
      bus.mem_rdata = $urandom;
  end

  always @(negedge clk) begin
    chk("mem_addr", bus.mem_addr, e_maddr);
    chk("mem_wr", 32'(bus.mem_wr), 32'(e_wr));
    chk("mem_wdata", bus.mem_wdata, e_wdata);
    chk("ld_data", bus.ld_data, e_ld);
    chk("datasrc_sel", 32'(bus.datasrc_sel), 32'(e_sel));
    chk("reg_wr", 32'(bus.reg_wr), 32'(e_rw));
    chk("busy", 32'(bus.busy), 32'(m_busy));
    chk("done", 32'(bus.done), 32'(e_done));
    chk("exc", 32'(bus.exc), 32'(e_exc));
  end

  // Leaves the caller at the negedge of cycle 1 of the new request.
  task automatic go(input logic [2:0] o, input logic [31:0] a,
                    input logic [31:0] d);
    int g;
    g = 0;
    @(negedge clk);
    while (m_busy && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) begin
      n_cmp++; n_bad++;
      $display("FAIL go_timeout: got busy want idle");
    end
    bus.start = 1'b1; bus.op = o; bus.addr = a; bus.st_data = d;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bus.start = 0; bus.op = 0; bus.addr = 0; bus.st_data = 0;
    #1;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_maddr", bus.mem_addr, 0);
    chk("rst_ld", bus.ld_data, 0);
    cyc(3);
    reset = 1'b0;

    go(3'b100, 32'h10, 32'h800000FF);
    go(3'b000, 32'h10, 0);
    chk("lw_sel_c1", 32'(bus.datasrc_sel), 0);
    cyc(2);
    chk("lw_regwr", 32'(bus.reg_wr), 1);
    chk("lw_sel", 32'(bus.datasrc_sel), 1);
    chk("lw_ld", bus.ld_data, 32'h800000FF);
    chk("lw_done", 32'(bus.done), 1);

    go(3'b100, 32'h10, 32'h80112233);
    go(3'b010, 32'h13, 0);
    chk("lb_maddr", bus.mem_addr, 32'h10);
    cyc(2);
    chk("lb_ld", bus.ld_data, 32'hFFFFFF80);
    go(3'b001, 32'h12, 0);
    chk("lh_maddr", bus.mem_addr, 32'h10);
    cyc(2);
    chk("lh_ld", bus.ld_data, 32'hFFFF8011);

    go(3'b100, 32'h20, 32'h11223344);
    go(3'b110, 32'h21, 32'h000000AB);
    cyc(2);
    chk("sb_maddr", bus.mem_addr, 32'h20);
    chk("sb_wr", 32'(bus.mem_wr), 1);
    chk("sb_wdata", bus.mem_wdata, 32'h1122AB44);
    chk("sb_regwr", 32'(bus.reg_wr), 0);
    chk("sb_model", mem[8], 32'h1122AB44);

    go(3'b100, 32'h40, 32'hDEADBEEF);
    chk("sw_wr", 32'(bus.mem_wr), 1);
    chk("sw_wdata", bus.mem_wdata, 32'hDEADBEEF);
    chk("sw_busy", 32'(bus.busy), 1);
    cyc(1);
    chk("sw_busy_c2", 32'(bus.busy), 0);

    go(3'b001, 32'h11, 0);
`ifdef LS_MISALIGN_TRAP_EN
    chk("lhm_exc", 32'(bus.exc), 1);
    chk("lhm_done", 32'(bus.done), 1);
    chk("lhm_wr", 32'(bus.mem_wr), 0);
`else
    cyc(2);
    chk("lhm_ld", bus.ld_data, 32'h00002233);
    chk("lhm_done", 32'(bus.done), 1);
`endif

    go(3'b011, 32'h10, 0);
    chk("ill_exc", 32'(bus.exc), 1);
    chk("ill_done", 32'(bus.done), 1);

    go(3'b000, 32'h10, 0);
    bus.start = 1'b1;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mrst_busy", 32'(bus.busy), 0);
    chk("mrst_maddr", bus.mem_addr, 0);
    chk("mrst_wdata", bus.mem_wdata, 0);
    chk("mrst_ld", bus.ld_data, 0);
    bus.start = 1'b0;
    cyc(2);
    reset = 1'b0;
    go(3'b100, 32'h14, 32'h12345678);
    go(3'b000, 32'h14, 0);
    cyc(2);
    chk("post_done", 32'(bus.done), 1);
    chk("post_ld", bus.ld_data, 32'h12345678);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      bus.start = 1'($urandom_range(0, 1));
      bus.op = 3'($urandom_range(0, 7));
      bus.addr = 32'($urandom_range(0, 255));
      bus.st_data = $urandom;
    end
    bus.start = 1'b0;
    cyc(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
